memory_lsu: RTL and testbench

- Parametrised successor to the single-port 32-bit inferred data memory.
- Adds byte-addressed sub-word access per RISC-V funct3 (byte/half/word, signed/unsigned loads), byte-lane write enables and misalignment/illegal-op detection.
- Read-during-write mode and an optional output pipeline register are selected by parameter.
- Sits behind the core's load/store unit.
- Must infer a single sysMEM/LUTRAM array with byte enables.

---
 rtl/memory_lsu.sv | 183 ++++++++++++++++++
 tb/tb_memory_lsu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_lsu.sv
// memory_lsu: byte-addressed data memory behind the load/store unit.
// RISC-V sub-word loads/stores, byte-lane writes, error flagging.
module memory_lsu #(
  parameter int    ADDR_WIDTH  = 13,
  parameter int    WRITE_FIRST = 0,
  parameter int    OUT_REG     = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_writedata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] idx;
  logic [1:0]            lane;
  logic                  f3_ok;
  logic                  misal;
  logic                  err;
  logic [3:0]            be;
  logic [31:0]           wword;
  logic                  wr_en;
  logic                  rd_en;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  logic        s1_valid_q;
  logic        s1_live_q;
  logic        s1_err_q;
  logic        s1_we_q;
  logic [2:0]  s1_f3_q;
  logic [1:0]  s1_lane_q;
  logic [3:0]  s1_be_q;
  logic [31:0] s1_wdata_q;

  logic [31:0] word;
  logic [31:0] shifted;
  logic [31:0] ext;
  logic [31:0] data_d;

  logic unused_addr;

  assign idx  = req_addr[ADDR_WIDTH+1:2];
  assign lane = req_addr[1:0];
  assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];

  always_comb begin
    f3_ok = 1'b1;
    misal = 1'b0;
    be    = 4'b0000;
    wword = req_writedata;
    unique case (1'b1)
      (req_funct3 == 3'b000),
      (req_funct3 == 3'b100): begin
        be    = 4'b0001 << lane;
        wword = {4{req_writedata[7:0]}};
      end
      (req_funct3 == 3'b001),
      (req_funct3 == 3'b101): begin
        misal = lane[0];
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{req_writedata[15:0]}};
      end
      (req_funct3 == 3'b010): begin
        misal = |lane;
        be    = 4'b1111;
      end
      default: f3_ok = 1'b0;
    endcase
    if (req_we && req_funct3[2]) begin
      f3_ok = 1'b0;
    end
  end

  assign err   = !f3_ok || misal;
  assign rd_en = req_valid && !reset;
  assign wr_en = rd_en && req_we && !err;

  always_ff @(posedge clock) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem_q[idx];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_live_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_we_q    <= 1'b0;
      s1_f3_q    <= 3'b000;
      s1_lane_q  <= 2'b00;
      s1_be_q    <= 4'b0000;
      s1_wdata_q <= 32'h0;
    end else begin
      s1_valid_q <= req_valid;
      if (req_valid) begin
        s1_live_q  <= 1'b1;
        s1_err_q   <= err;
        s1_we_q    <= req_we;
        s1_f3_q    <= req_funct3;
        s1_lane_q  <= lane;
        s1_be_q    <= be;
        s1_wdata_q <= wword;
      end
    end
  end

  always_comb begin
    word = rdata_q;
    if (WRITE_FIRST != 0 && s1_we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (s1_be_q[i]) begin
          word[8*i +: 8] = s1_wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign shifted = word >> {s1_lane_q, 3'b000};

  always_comb begin
    ext = word;
    unique case (1'b1)
      (s1_f3_q == 3'b000):
        ext = {{24{shifted[7]}}, shifted[7:0]};
      (s1_f3_q == 3'b100):
        ext = {24'h0, shifted[7:0]};
      (s1_f3_q == 3'b001):
        ext = {{16{shifted[15]}}, shifted[15:0]};
      (s1_f3_q == 3'b101):
        ext = {16'h0, shifted[15:0]};
      default: ext = word;
    endcase
  end

  assign data_d = (s1_live_q && !s1_err_q) ? ext : 32'h0;

  if (OUT_REG != 0) begin : g_oreg
    logic        o_valid_q;
    logic [31:0] o_data_q;
    logic        o_err_q;

    always_ff @(posedge clock) begin
      if (reset) begin
        o_valid_q <= 1'b0;
        o_data_q  <= 32'h0;
        o_err_q   <= 1'b0;
      end else begin
        o_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          o_data_q <= data_d;
          o_err_q  <= s1_err_q;
        end
      end
    end

    assign resp_valid = o_valid_q;
    assign resp_data  = o_data_q;
    assign resp_error = o_err_q;
  end else begin : g_comb
    assign resp_valid = s1_valid_q;
    assign resp_data  = data_d;
    assign resp_error = s1_err_q;
  end

endmodule

// File: tb/tb_memory_lsu.sv
// tb_memory_lsu: two configurations (read-first/comb, write-first/
// registered) driven in lockstep against a byte-array model.
module tb_memory_lsu;

  logic        clk;
  logic        rst;
  logic        rv;
  logic        rwe;
  logic [2:0]  rf3;
  logic [31:0] raddr;
  logic [31:0] rwd;
  logic        v0, v1, e0, e1;
  logic [31:0] d0, d1;

  int ncmp;
  int nerr;

  // model: byte memory (256 words) and expected outputs per DUT
  logic [7:0]  mm [1024];
  logic        x0v, x0e, x1v, x1e, m1v, m1e;
  logic [31:0] x0d, x1d, m1d;

  memory_lsu #(
    .ADDR_WIDTH(8), .WRITE_FIRST(0), .OUT_REG(0), .INIT_FILE("")
  ) u_dut0 (
    .clock(clk), .reset(rst), .req_valid(rv), .req_we(rwe),
    .req_funct3(rf3), .req_addr(raddr), .req_writedata(rwd),
    .resp_valid(v0), .resp_data(d0), .resp_error(e0)
  );

  memory_lsu #(
    .ADDR_WIDTH(8), .WRITE_FIRST(1), .OUT_REG(1), .INIT_FILE("")
  ) u_dut1 (
    .clock(clk), .reset(rst), .req_valid(rv), .req_we(rwe),
    .req_funct3(rf3), .req_addr(raddr), .req_writedata(rwd),
    .resp_valid(v1), .resp_data(d1), .resp_error(e1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic is_err(input logic we, input logic [2:0] f3,
                                  input logic [31:0] ad);
    case (f3)
      3'd0: return 1'b0;
      3'd1: return ad[0];
      3'd2: return ad[1:0] != 2'b00;
      3'd4: return we;
      3'd5: return we || ad[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] f3, input int a);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < nbytes(f3); i++) v = v | (32'(mm[a+i]) << (8*i));
    if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
    if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  // one clock: drive request, advance model, settle 1 time unit past edge
  task automatic step(input logic r, input logic v, input logic we,
                      input logic [2:0] f3, input logic [31:0] ad,
                      input logic [31:0] wd);
    logic e;
    logic [31:0] o, n;
    int a;
    rst = r; rv = v; rwe = we; rf3 = f3; raddr = ad; rwd = wd;
    @(posedge clk);
    if (r) begin
      x0v = 0; x0d = 0; x0e = 0;
      x1v = 0; x1d = 0; x1e = 0;
      m1v = 0; m1d = 0; m1e = 0;
    end else begin
      if (m1v) begin x1v = 1; x1d = m1d; x1e = m1e; end
      else x1v = 0;
      if (v) begin
        e = is_err(we, f3, ad);
        o = 0; n = 0;
        if (!e) begin
          a = int'(ad[9:0]);
          o = load_val(f3, a);
          if (we) begin
            for (int i = 0; i < nbytes(f3); i++) mm[a+i] = wd[8*i +: 8];
          end
          n = load_val(f3, a);
        end
        x0v = 1; x0d = o; x0e = e;
        m1v = 1; m1d = n; m1e = e;
      end else begin
        x0v = 0; m1v = 0;
      end
    end
    #1;
  endtask

  task automatic test_preload();
    for (int w = 0; w < 256; w++) begin
      step(0, 1, 1, 3'd2, 32'(w * 4), $urandom);
      ncmp++; if (v0 !== 1'b1) begin nerr++; $display("FAIL preload.v0 w=%0d got %b exp 1", w, v0); end
    end
    step(0, 0, 0, 3'd0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 1, 3'd2, 32'h0, 32'h5555_5555);
      ncmp++; if (v0 !== 1'b0) begin nerr++; $display("FAIL reset.v0 got %b exp 0", v0); end
      ncmp++; if (d0 !== 32'h0) begin nerr++; $display("FAIL reset.d0 got %h exp 0", d0); end
      ncmp++; if (e0 !== 1'b0) begin nerr++; $display("FAIL reset.e0 got %b exp 0", e0); end
      ncmp++; if (v1 !== 1'b0) begin nerr++; $display("FAIL reset.v1 got %b exp 0", v1); end
      ncmp++; if (d1 !== 32'h0) begin nerr++; $display("FAIL reset.d1 got %h exp 0", d1); end
      ncmp++; if (e1 !== 1'b0) begin nerr++; $display("FAIL reset.e1 got %b exp 0", e1); end
    end
    step(0, 0, 0, 3'd0, 0, 0);
    ncmp++; if (v0 !== 1'b0) begin nerr++; $display("FAIL reset.idle_v0 got %b exp 0", v0); end
    ncmp++; if (v1 !== 1'b0) begin nerr++; $display("FAIL reset.idle_v1 got %b exp 0", v1); end
  endtask

  task automatic test_directed();
    logic        we_t [14] = '{1,0,0,0,0,0,1,0,1,0,0,1,0,0};
    logic [2:0]  f3_t [14] = '{2,2,0,4,1,5,0,2,2,2,3,5,1,2};
    logic [31:0] ad_t [14] = '{32'h100, 32'h100, 32'h101, 32'h101,
                               32'h102, 32'h100, 32'h103, 32'h100,
                               32'h202, 32'h200, 32'h000, 32'h100,
                               32'h101, 32'h100};
    logic [31:0] wd_t [14] = '{32'hDEADBEEF, 0, 0, 0, 0, 0, 32'h12, 0,
                               32'h11111111, 0, 0, 32'hABCD, 0, 0};
    logic        lk_t [14] = '{0,1,1,1,1,1,1,1,1,0,1,1,1,1};
    logic [31:0] lt_t [14] = '{0, 32'hDEADBEEF, 32'hFFFFFFBE,
                               32'h000000BE, 32'hFFFFDEAD,
                               32'h0000BEEF, 32'hFFFFFFDE,
                               32'h12ADBEEF, 0, 0, 0, 0, 0,
                               32'h12ADBEEF};
    logic        le_t [14] = '{0,0,0,0,0,0,0,0,1,0,1,1,1,0};
    for (int i = 0; i < 14; i++) begin
      step(0, 1, we_t[i], f3_t[i], ad_t[i], wd_t[i]);
      if (lk_t[i]) begin
        ncmp++; if (d0 !== lt_t[i]) begin nerr++; $display("FAIL dir.lit_d0 i=%0d got %h exp %h", i, d0, lt_t[i]); end
        ncmp++; if (e0 !== le_t[i]) begin nerr++; $display("FAIL dir.lit_e0 i=%0d got %b exp %b", i, e0, le_t[i]); end
      end
      if (i == 7) begin
        ncmp++; if (d1 !== 32'h12) begin nerr++; $display("FAIL dir.sb_wf1 got %h exp 00000012", d1); end
      end
      ncmp++; if (v0 !== x0v) begin nerr++; $display("FAIL dir.v0 i=%0d got %b exp %b", i, v0, x0v); end
      ncmp++; if (d0 !== x0d) begin nerr++; $display("FAIL dir.d0 i=%0d got %h exp %h", i, d0, x0d); end
      ncmp++; if (e0 !== x0e) begin nerr++; $display("FAIL dir.e0 i=%0d got %b exp %b", i, e0, x0e); end
      ncmp++; if (v1 !== x1v) begin nerr++; $display("FAIL dir.v1 i=%0d got %b exp %b", i, v1, x1v); end
      ncmp++; if (d1 !== x1d) begin nerr++; $display("FAIL dir.d1 i=%0d got %h exp %h", i, d1, x1d); end
      ncmp++; if (e1 !== x1e) begin nerr++; $display("FAIL dir.e1 i=%0d got %b exp %b", i, e1, x1e); end
    end
  endtask

  task automatic test_pipeline();
    for (int i = 0; i < 4; i++) step(0, 1, 1, 3'd2, 32'(4*i), 32'(i+1));
    step(0, 0, 0, 3'd0, 0, 0);
    step(0, 0, 0, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 3'd2, 32'(4*i), 0);
      ncmp++; if (d0 !== 32'(i+1)) begin nerr++; $display("FAIL pipe.d0 i=%0d got %h exp %h", i, d0, i+1); end
      ncmp++; if (v1 !== (i != 0)) begin nerr++; $display("FAIL pipe.v1 i=%0d got %b exp %b", i, v1, i != 0); end
      if (i != 0) begin
        ncmp++; if (d1 !== 32'(i)) begin nerr++; $display("FAIL pipe.d1 i=%0d got %h exp %h", i, d1, i); end
      end
    end
    step(0, 0, 0, 3'd0, 0, 0);
    ncmp++; if (v1 !== 1'b1) begin nerr++; $display("FAIL pipe.v1_last got %b exp 1", v1); end
    ncmp++; if (d1 !== 32'd4) begin nerr++; $display("FAIL pipe.d1_last got %h exp 4", d1); end
    ncmp++; if (v0 !== 1'b0) begin nerr++; $display("FAIL pipe.v0_idle got %b exp 0", v0); end
    step(0, 0, 0, 3'd0, 0, 0);
    ncmp++; if (v1 !== 1'b0) begin nerr++; $display("FAIL pipe.v1_idle got %b exp 0", v1); end
    ncmp++; if (d1 !== 32'd4) begin nerr++; $display("FAIL pipe.d1_hold got %h exp 4", d1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ad;
    logic [2:0]  f3;
    for (int k = 0; k < 80; k++) begin
      f3 = 3'($urandom_range(0, 2));
      ad = 32'($urandom_range(0, 7) * 4 + 32'h40);
      if (k[0]) begin
        if (f3 == 3'd0) ad[1:0] = 2'($urandom_range(0, 3));
        if (f3 == 3'd1) ad[1] = 1'($urandom_range(0, 1));
        step(0, 1, 1, f3, ad, $urandom);
      end else begin
        step(0, 1, 0, 3'd2, ad & 32'hFFFF_FFFC, 0);
      end
      ncmp++; if (v0 !== x0v) begin nerr++; $display("FAIL b2b.v0 k=%0d got %b exp %b", k, v0, x0v); end
      ncmp++; if (d0 !== x0d) begin nerr++; $display("FAIL b2b.d0 k=%0d got %h exp %h", k, d0, x0d); end
      ncmp++; if (e0 !== x0e) begin nerr++; $display("FAIL b2b.e0 k=%0d got %b exp %b", k, e0, x0e); end
      ncmp++; if (v1 !== x1v) begin nerr++; $display("FAIL b2b.v1 k=%0d got %b exp %b", k, v1, x1v); end
      ncmp++; if (d1 !== x1d) begin nerr++; $display("FAIL b2b.d1 k=%0d got %h exp %h", k, d1, x1d); end
      ncmp++; if (e1 !== x1e) begin nerr++; $display("FAIL b2b.e1 k=%0d got %b exp %b", k, e1, x1e); end
    end
  endtask

  task automatic test_random();
    logic [31:0] t, ad;
    logic [2:0]  f3;
    int          k;
    for (int i = 0; i < 600; i++) begin
      t = $urandom;
      k = $urandom_range(0, 9);
      f3 = (k > 7) ? 3'd2 : 3'(k);
      // upper bits random: exercises word-index aliasing
      ad = {t[31:10], 5'b0, t[4:0]};
      if (t[5]) begin
        if (f3[1:0] == 2'b10) ad[1:0] = 2'b00;
        else ad[0] = 1'b0;
      end
      step(0, ($urandom_range(0, 4) != 0), t[20], f3, ad, $urandom);
      ncmp++; if (v0 !== x0v) begin nerr++; $display("FAIL rnd.v0 i=%0d got %b exp %b", i, v0, x0v); end
      ncmp++; if (d0 !== x0d) begin nerr++; $display("FAIL rnd.d0 i=%0d got %h exp %h", i, d0, x0d); end
      ncmp++; if (e0 !== x0e) begin nerr++; $display("FAIL rnd.e0 i=%0d got %b exp %b", i, e0, x0e); end
      ncmp++; if (v1 !== x1v) begin nerr++; $display("FAIL rnd.v1 i=%0d got %b exp %b", i, v1, x1v); end
      ncmp++; if (d1 !== x1d) begin nerr++; $display("FAIL rnd.d1 i=%0d got %h exp %h", i, d1, x1d); end
      ncmp++; if (e1 !== x1e) begin nerr++; $display("FAIL rnd.e1 i=%0d got %b exp %b", i, e1, x1e); end
    end
  endtask

  task automatic test_reset_inflight();
    step(0, 1, 1, 3'd2, 32'h300, 32'hCAFEF00D);
    ncmp++; if (v0 !== 1'b1) begin nerr++; $display("FAIL rsti.v0_store got %b exp 1", v0); end
    step(1, 1, 1, 3'd2, 32'h300, 32'h0);
    ncmp++; if (v0 !== 1'b0) begin nerr++; $display("FAIL rsti.v0 got %b exp 0", v0); end
    ncmp++; if (d0 !== 32'h0) begin nerr++; $display("FAIL rsti.d0 got %h exp 0", d0); end
    ncmp++; if (e0 !== 1'b0) begin nerr++; $display("FAIL rsti.e0 got %b exp 0", e0); end
    ncmp++; if (v1 !== 1'b0) begin nerr++; $display("FAIL rsti.v1 got %b exp 0", v1); end
    ncmp++; if (d1 !== 32'h0) begin nerr++; $display("FAIL rsti.d1 got %h exp 0", d1); end
    ncmp++; if (e1 !== 1'b0) begin nerr++; $display("FAIL rsti.e1 got %b exp 0", e1); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 3'd0, 0, 0);
      ncmp++; if (v0 !== 1'b0) begin nerr++; $display("FAIL rsti.post_v0 i=%0d got %b exp 0", i, v0); end
      ncmp++; if (v1 !== 1'b0) begin nerr++; $display("FAIL rsti.post_v1 i=%0d got %b exp 0", i, v1); end
    end
    step(0, 1, 0, 3'd2, 32'h300, 0);
    ncmp++; if (v0 !== 1'b1) begin nerr++; $display("FAIL rsti.lw_v0 got %b exp 1", v0); end
    ncmp++; if (d0 !== 32'hCAFEF00D) begin nerr++; $display("FAIL rsti.lw_d0 got %h exp cafef00d", d0); end
    ncmp++; if (e0 !== 1'b0) begin nerr++; $display("FAIL rsti.lw_e0 got %b exp 0", e0); end
    step(0, 0, 0, 3'd0, 0, 0);
    ncmp++; if (v1 !== 1'b1) begin nerr++; $display("FAIL rsti.lw_v1 got %b exp 1", v1); end
    ncmp++; if (d1 !== 32'hCAFEF00D) begin nerr++; $display("FAIL rsti.lw_d1 got %h exp cafef00d", d1); end
  endtask

  initial begin
    ncmp = 0;
    nerr = 0;
    rst = 1; rv = 0; rwe = 0; rf3 = 0; raddr = 0; rwd = 0;
    x0v = 0; x0d = 0; x0e = 0;
    x1v = 0; x1d = 0; x1e = 0;
    m1v = 0; m1d = 0; m1e = 0;
    step(1, 0, 0, 3'd0, 0, 0);
    step(1, 0, 0, 3'd0, 0, 0);
    test_preload();
    test_reset();
    test_directed();
    test_pipeline();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
